// File: rtl/cmp_bist_pkg.sv
// cmp_bist_pkg: shared state encoding, mode encoding and default constants for the comparator pattern BIST
package cmp_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  localparam logic MODE_EXH = 1'b0;
  localparam logic MODE_LFSR = 1'b1;
  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_LFSR_SEED = 8'h01;
endpackage

// File: rtl/bist_misr_serial.sv
// bist_misr_serial: serial-input signature register (clk, clr, en, din -> sig) with CRC-style feedback polynomial
module bist_misr_serial #(
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);
  logic fb;
  assign fb = sig[SIG_W-1] ^ din;
  always_ff @(posedge clk)
    if (clr) sig <= '0;
    else if (en) sig <= {sig[SIG_W-2:0], 1'b0} ^ ({SIG_W{fb}} & SIG_POLY);
endmodule

// File: rtl/cmp_pattern_bist.sv
// cmp_pattern_bist: drives pattin={a,b}, compacts pattout into signature, flags pass vs golden_sig (start/mode launch; busy/done/pass/pat_count status)
module cmp_pattern_bist
  import cmp_bist_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = DEF_SIG_POLY,
  parameter logic [PAT_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [PAT_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             pattout,
  output logic [PAT_W-1:0] pattin,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [PAT_W:0]   pat_count
);
  state_t state;
  logic mode_q;
  logic launch;
  logic [PAT_W-1:0] pat_next;
  logic [PAT_W:0] cnt_next;
  logic [PAT_W:0] run_len;
  assign launch = (state == IDLE || state == DONE) && start;
  assign pat_next = mode_q == MODE_LFSR ? {pattin[PAT_W-2:0], ^(pattin & LFSR_TAPS)} : pattin + 1'b1;
  assign cnt_next = pat_count + 1'b1;
  assign run_len = mode_q == MODE_LFSR ? {1'b0, {PAT_W{1'b1}}} : {1'b1, {PAT_W{1'b0}}};
  bist_misr_serial #(.SIG_W(SIG_W), .SIG_POLY(SIG_POLY)) u_misr (
    .clk(clk),
    .clr(!rst_n || launch),
    .en(state == RUN),
    .din(pattout),
    .sig(signature)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= MODE_EXH;
      pattin <= '0;
      pat_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= RUN;
            mode_q <= mode;
            pattin <= mode == MODE_LFSR ? LFSR_SEED : '0;
            pat_count <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
          end
        RUN: begin
          pattin <= pat_next;
          pat_count <= cnt_next;
          if (cnt_next == run_len) state <= CHECK;
        end
        CHECK: begin
          pass <= signature == golden_sig;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_cmp_pattern_bist.sv
// tb_cmp_pattern_bist: directed self-checking bench for cmp_pattern_bist with a modelled 4-bit cmpge response
module tb_cmp_pattern_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [15:0] golden_sig = '0;
  logic pattout;
  logic [7:0] pattin;
  logic busy, done, pass;
  logic [15:0] signature;
  logic [8:0] pat_count;
  logic [1:0] src = 2'd0;
  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt;
  logic [15:0] first_sig;
  logic [7:0] pats [0:255];
  logic [15:0] gold;

  always #5 clk = ~clk;

  assign pattout = src == 2'd1 ? 1'b1 : src == 2'd2 ? (pattin[7:4] >= pattin[3:0]) : 1'b0;

  cmp_pattern_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .golden_sig(golden_sig),
    .pattout(pattout), .pattin(pattin), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_count(pat_count)
  );

  function automatic logic resp(input logic [1:0] s, input logic [7:0] p);
    return s == 2'd1 ? 1'b1 : s == 2'd2 ? (p[7:4] >= p[3:0]) : 1'b0;
  endfunction

  function automatic logic [15:0] model_sig(input logic m, input logic [1:0] s);
    logic [7:0] p;
    logic [15:0] sg;
    logic fb;
    p = m ? 8'h01 : 8'h00;
    sg = '0;
    for (int i = 0; i < (m ? 255 : 256); i++) begin
      fb = sg[15] ^ resp(s, p);
      sg = (sg << 1) ^ (fb ? 16'h1021 : 16'h0000);
      p = m ? {p[6:0], ^(p & 8'hB8)} : p + 8'd1;
    end
    return sg;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic m, input logic [1:0] s, input logic [15:0] g);
    src = s;
    golden_sig = g;
    mode = m;
    start = 1'b1;
    tick;
    start = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 600) begin
      if (busy_cnt < 256) pats[busy_cnt] = pattin;
      busy_cnt++;
      tick;
      if (busy_cnt == 1) first_sig = signature;
    end
    n_cmp++;
    if (busy_cnt >= 600) begin
      n_err++;
      $display("FAIL run_timeout busy_cnt=%0d required<600", busy_cnt);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp += 6;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy got=%b exp=0", tag, busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL %s_done got=%b exp=0", tag, done); end
    if (pass !== 1'b0) begin n_err++; $display("FAIL %s_pass got=%b exp=0", tag, pass); end
    if (signature !== 16'h0) begin n_err++; $display("FAIL %s_sig got=%h exp=0000", tag, signature); end
    if (pattin !== 8'h0) begin n_err++; $display("FAIL %s_pattin got=%h exp=00", tag, pattin); end
    if (pat_count !== 9'd0) begin n_err++; $display("FAIL %s_count got=%0d exp=0", tag, pat_count); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    check_idle_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_exh_zero;
    int walk_err;
    run(1'b0, 2'd0, 16'h0000);
    walk_err = 0;
    for (int i = 0; i < 256; i++) if (pats[i] !== i[7:0]) walk_err++;
    n_cmp += 6;
    if (busy_cnt !== 257) begin n_err++; $display("FAIL exh0_busy_cycles got=%0d exp=257", busy_cnt); end
    if (walk_err !== 0) begin n_err++; $display("FAIL exh0_walk bad_steps=%0d exp=0", walk_err); end
    if (signature !== 16'h0000) begin n_err++; $display("FAIL exh0_sig got=%h exp=0000", signature); end
    if (pat_count !== 9'd256) begin n_err++; $display("FAIL exh0_count got=%0d exp=256", pat_count); end
    if (done !== 1'b1) begin n_err++; $display("FAIL exh0_done got=%b exp=1", done); end
    if (pass !== 1'b1) begin n_err++; $display("FAIL exh0_pass got=%b exp=1", pass); end
  endtask

  task automatic test_exh_one;
    gold = model_sig(1'b0, 2'd1);
    run(1'b0, 2'd1, gold);
    n_cmp += 3;
    if (first_sig !== 16'h1021) begin n_err++; $display("FAIL exh1_first_sig got=%h exp=1021", first_sig); end
    if (signature !== gold) begin n_err++; $display("FAIL exh1_sig got=%h exp=%h", signature, gold); end
    if (pass !== 1'b1) begin n_err++; $display("FAIL exh1_pass_good got=%b exp=1", pass); end
    run(1'b0, 2'd1, gold ^ 16'h0001);
    n_cmp++;
    if (pass !== 1'b0) begin n_err++; $display("FAIL exh1_pass_bad got=%b exp=0", pass); end
  endtask

  task automatic test_lfsr;
    logic [7:0] expv [0:4];
    logic [255:0] seen;
    int dup_err;
    expv = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    gold = model_sig(1'b1, 2'd2);
    run(1'b1, 2'd2, gold);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (pats[i] !== expv[i]) begin n_err++; $display("FAIL lfsr_seq%0d got=%h exp=%h", i, pats[i], expv[i]); end
    end
    seen = '0;
    dup_err = 0;
    for (int i = 0; i < 255; i++) begin
      if (pats[i] === 8'h00 || seen[pats[i]]) dup_err++;
      seen[pats[i]] = 1'b1;
    end
    n_cmp += 4;
    if (dup_err !== 0) begin n_err++; $display("FAIL lfsr_distinct bad=%0d exp=0", dup_err); end
    if (busy_cnt !== 256) begin n_err++; $display("FAIL lfsr_busy_cycles got=%0d exp=256", busy_cnt); end
    if (pat_count !== 9'd255) begin n_err++; $display("FAIL lfsr_count got=%0d exp=255", pat_count); end
    if (pass !== 1'b1) begin n_err++; $display("FAIL lfsr_pass got=%b exp=1 sig=%h gold=%h", pass, signature, gold); end
  endtask

  task automatic test_fault;
    gold = model_sig(1'b0, 2'd2);
    run(1'b0, 2'd2, gold);
    n_cmp++;
    if (pass !== 1'b1) begin n_err++; $display("FAIL fault_free_pass got=%b exp=1", pass); end
    run(1'b0, 2'd3, gold);
    n_cmp += 2;
    if (pass !== 1'b0) begin n_err++; $display("FAIL stuck0_pass got=%b exp=0", pass); end
    if (signature !== 16'h0000) begin n_err++; $display("FAIL stuck0_sig got=%h exp=0000", signature); end
  endtask

  task automatic test_reset_mid;
    int n;
    src = 2'd1;
    mode = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (pat_count !== 9'd100 && n < 300) begin n++; tick; end
    n_cmp++;
    if (pat_count !== 9'd100) begin n_err++; $display("FAIL mid_reach100 got=%0d exp=100", pat_count); end
    rst_n = 1'b0;
    tick;
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    tick;
    gold = model_sig(1'b0, 2'd1);
    run(1'b0, 2'd1, gold);
    n_cmp += 3;
    if (pat_count !== 9'd256) begin n_err++; $display("FAIL mid_rerun_count got=%0d exp=256", pat_count); end
    if (signature !== gold) begin n_err++; $display("FAIL mid_rerun_sig got=%h exp=%h", signature, gold); end
    if (pass !== 1'b1) begin n_err++; $display("FAIL mid_rerun_pass got=%b exp=1", pass); end
  endtask

  task automatic test_back_to_back;
    int n;
    src = 2'd0;
    golden_sig = 16'h0000;
    mode = 1'b0;
    start = 1'b1;
    tick;
    n = 0;
    while (busy && n < 600) begin
      n++;
      if (n == 50) mode = 1'b1;
      tick;
    end
    n_cmp += 4;
    if (n !== 257) begin n_err++; $display("FAIL b2b_busy_cycles got=%0d exp=257", n); end
    if (pat_count !== 9'd256) begin n_err++; $display("FAIL b2b_count got=%0d exp=256", pat_count); end
    if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_first got=%b exp=1", done); end
    if (pass !== 1'b1) begin n_err++; $display("FAIL b2b_pass got=%b exp=1", pass); end
    tick;
    start = 1'b0;
    n_cmp += 4;
    if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_relaunch_busy got=%b exp=1", busy); end
    if (pattin !== 8'h01) begin n_err++; $display("FAIL b2b_relaunch_pattin got=%h exp=01", pattin); end
    if (pat_count !== 9'd0) begin n_err++; $display("FAIL b2b_relaunch_count got=%0d exp=0", pat_count); end
    n = 0;
    while (busy && n < 600) begin n++; tick; end
    n_cmp += 2;
    if (pat_count !== 9'd255) begin n_err++; $display("FAIL b2b_lfsr_count got=%0d exp=255", pat_count); end
    if (pass !== 1'b1) begin n_err++; $display("FAIL b2b_lfsr_pass got=%b exp=1", pass); end
  endtask

  initial begin
    test_reset;
    test_exh_zero;
    test_exh_one;
    test_lfsr;
    test_fault;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
